zero_flag_decoder_row: RTL and testbench
========================================

// Module: zero_flag_decoder_row
// PURPOSE
//  Receive side of the zero-flag activation encoding: consumes one row vector of
//  (bw+1)-bit lanes, {zero_flag, data[bw-1:0]}, and sits between the encoder and the
//  PE array row inputs. Per lane it produces clean data, a PE gate enable and a flag
//  consistency error. A 2-entry skid buffer provides valid/ready flow control, and
//  saturating counters record sparsity statistics.
// PARAMETERS
//  bw      4   activation width per lane (bits)
//  row     8   lanes per vector
//  cnt_bw  16  width of the statistics counters
// PORTS
//  clk        in   1             clock, rising edge
//  reset      in   1             asynchronous, active-high reset
//  in         in   row*(bw+1)    lane i = in[(bw+1)*(i+1)-1 : i*(bw+1)]; MSB = zero_flag
//  in_valid   in   1             input vector valid
//  in_ready   out  1             buffer can accept a vector
//  out        out  row*bw        decoded data, lane i = out[bw*(i+1)-1 : bw*i]
//  out_valid  out  1             output vector valid
//  out_ready  in   1             downstream accepts the vector
//  gate_en    out  row           lane i = !zero_flag; 1 = the PE must compute
//  all_zero   out  1             every flag in the head vector is set (vector skippable)
//  flag_err   out  row           per-lane flag/data mismatch on the head vector
//  err_sticky out  1             set by any accepted beat with |flag_err; cleared by stat_clr
//  stat_clr   in   1             synchronous clear of the counters and err_sticky
//  zero_cnt   out  cnt_bw        total flagged-zero lanes handed off
//  vec_cnt    out  cnt_bw        total vectors handed off
// BEHAVIOUR
//  - Reset (asynchronous, takes effect immediately):
//    out_valid=0, in_ready=1, both buffer entries empty, zero_cnt=0, vec_cnt=0, err_sticky=0.
//    Registered data is cleared to 0, so out, gate_en, flag_err and all_zero read 0.
//  - Buffer: a head (output) register plus a skid register, entry order preserved.
//    in_ready is a register and equals "skid empty".
//  - Input accept: in_valid && in_ready at edge t gives out_valid=1 from t+1, i.e. 1-cycle
//    latency when empty.
//  - Head accepted (out_valid && out_ready) at the same edge as an input accept:
//    the skid entry (if any) or the new vector moves into the head.
//  - out_ready=0 with head full and an input accepted: the vector goes to skid.
//    in_ready=0 from the next cycle until the head drains.
//  - No combinational path exists from out_ready to in_ready.
//  - in_valid with in_ready=0: ignored, and the source must hold.
//  - Decode (combinational from the head register):
//    out lane = flag ? 0 : data; gate_en[i] = !flag[i]; all_zero = &flag.
//  - flag_err[i] = flag[i] ^ (data_i == 0), covering both the flagged-nonzero and the
//    unflagged-zero cases.
//  - Outputs hold their value while out_valid=0 (last head contents); consumers must qualify
//    them with out_valid.
//  - Stats update only on an output handshake:
//    vec_cnt += 1; zero_cnt += popcount(flag[row-1:0]).
//    Both saturate at 2^cnt_bw-1 and never wrap; zero_cnt clamps if the sum overflows.
//  - err_sticky is set on a handshake with |flag_err.
//  - stat_clr at the same edge as a handshake: the clear wins and that beat is not counted.
//    The buffer and data path are unaffected by stat_clr.
//  - Reset mid-stream discards both buffered vectors; nothing is emitted for them afterwards.
// TESTING
//  1. bw=4,row=8: in lanes7..0 = {1,0},{0,5},{1,0},{0,F},{1,0},{1,0},{0,1},{0,2},
//     out_ready=1 -> next cycle out=32'h0050F0012, gate_en=8'b01010011, all_zero=0;
//     after handshake zero_cnt=4, vec_cnt=1, flag_err=0.
//  2. Back-to-back vectors A, B, C with out_ready=0 for 3 cycles -> A in head, B in skid,
//     in_ready=0 with C held. out_ready=1 -> A, B, C emitted on consecutive cycles, no loss,
//     no duplication.
//  3. Lane 2 = {1,3} and lane 5 = {0,0} -> out lane2=0, flag_err=8'b00100100;
//     err_sticky=1 after handshake; holds until stat_clr, then 0.
//  4. cnt_bw=4, 20 all-zero vectors streamed -> all_zero=1 each beat;
//     zero_cnt=15 and vec_cnt=15 (saturated, no wrap).
//  5. stat_clr asserted on the same edge as a handshake of a 3-zero vector ->
//     zero_cnt=0, vec_cnt=0 the next cycle.
//  6. reset asserted between clock edges with head and skid full ->
//     out_valid=0, in_ready=1, counters 0 before the next edge; first vector after release
//     has latency 1.

Source files
------------

// File: rtl/zero_flag_decoder_row_if.sv
// Row-vector bus between the zero-flag encoder side and the PE array row inputs.
// The master drives the vector and the downstream handshake; the slave is the decoder.
interface zero_flag_decoder_row_if #(
   parameter int bw     = 4,
   parameter int row    = 8,
   parameter int cnt_bw = 16
);
   logic [row*(bw+1)-1:0] in;
   logic                  in_valid;
   logic                  in_ready;
   logic [row*bw-1:0]     out;
   logic                  out_valid;
   logic                  out_ready;
   logic [row-1:0]        gate_en;
   logic                  all_zero;
   logic [row-1:0]        flag_err;
   logic                  err_sticky;
   logic                  stat_clr;
   logic [cnt_bw-1:0]     zero_cnt;
   logic [cnt_bw-1:0]     vec_cnt;

   modport master (
      output in, in_valid, out_ready, stat_clr,
      input  in_ready, out, out_valid, gate_en, all_zero, flag_err, err_sticky,
             zero_cnt, vec_cnt
   );

   modport slave (
      input  in, in_valid, out_ready, stat_clr,
      output in_ready, out, out_valid, gate_en, all_zero, flag_err, err_sticky,
             zero_cnt, vec_cnt
   );
endinterface

// File: rtl/zero_flag_decoder_row.sv
// Zero-flag row decoder: 2-entry skid buffer, per-lane data cleanup, PE gate enables,
// flag consistency check and saturating sparsity counters.
module zero_flag_decoder_row #(
   parameter int bw     = 4,
   parameter int row    = 8,
   parameter int cnt_bw = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   zero_flag_decoder_row_if.slave  bus
);
   localparam int lw = bw + 1;
   localparam int vw = row * lw;
   localparam int pw = $clog2(row + 1);

   // Head holds the already-decoded vector so a cleared head reads all-zero outputs.
   typedef struct packed {
      logic [row*bw-1:0] data;
      logic [row-1:0]    gate;
      logic [row-1:0]    err;
      logic              az;
   } head_t;

   function automatic head_t decode(input logic [vw-1:0] v);
      head_t          h;
      logic           flag;
      logic [bw-1:0]  d;
      h    = '0;
      h.az = 1'b1;
      for (int i = 0; i < row; i++) begin
         flag = v[lw*i+bw];
         d    = v[lw*i +: bw];
         h.data[bw*i +: bw] = flag ? '0 : d;
         h.gate[i]          = ~flag;
         h.err[i]           = flag ^ (d == '0);
         h.az               = h.az & flag;
      end
      return h;
   endfunction

   head_t             head_q, head_d;
   logic              head_valid_q, head_valid_d;
   logic [vw-1:0]     skid_q, skid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [cnt_bw-1:0] zero_cnt_q, zero_cnt_d;
   logic [cnt_bw-1:0] vec_cnt_q, vec_cnt_d;
   logic              err_sticky_q, err_sticky_d;

   logic              in_fire, out_fire;
   logic [pw-1:0]     pop;
   logic [cnt_bw:0]   zsum;

   assign bus.in_ready = ~skid_valid_q;
   assign in_fire      = bus.in_valid & ~skid_valid_q;
   assign out_fire     = head_valid_q & bus.out_ready;

   // NOTE: every always_comb output gets its hold value first so no latch is inferred.
   always_comb begin
      head_d       = head_q;
      head_valid_d = head_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (!head_valid_q || out_fire) begin
         if (skid_valid_q) begin
            head_d       = decode(skid_q);
            head_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            head_d       = decode(bus.in);
            head_valid_d = 1'b1;
         end else begin
            head_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_d       = bus.in;
         skid_valid_d = 1'b1;
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < row; i++) pop = pop + pw'(~head_q.gate[i]);
      zsum         = {1'b0, zero_cnt_q} + (cnt_bw+1)'(pop);
      zero_cnt_d   = zero_cnt_q;
      vec_cnt_d    = vec_cnt_q;
      err_sticky_d = err_sticky_q;
      if (bus.stat_clr) begin
         zero_cnt_d   = '0;
         vec_cnt_d    = '0;
         err_sticky_d = 1'b0;
      end else if (out_fire) begin
         vec_cnt_d    = (&vec_cnt_q) ? vec_cnt_q : vec_cnt_q + cnt_bw'(1);
         zero_cnt_d   = zsum[cnt_bw] ? '1 : zsum[cnt_bw-1:0];
         err_sticky_d = err_sticky_q | (|head_q.err);
      end
   end

   // NOTE: data registers are reset as well, so decoded outputs read 0 straight after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q       <= '0;
         head_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         zero_cnt_q   <= '0;
         vec_cnt_q    <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         head_valid_q <= head_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         zero_cnt_q   <= zero_cnt_d;
         vec_cnt_q    <= vec_cnt_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign bus.out        = head_q.data;
   assign bus.gate_en    = head_q.gate;
   assign bus.flag_err   = head_q.err;
   assign bus.all_zero   = head_q.az;
   assign bus.out_valid  = head_valid_q;
   assign bus.zero_cnt   = zero_cnt_q;
   assign bus.vec_cnt    = vec_cnt_q;
   assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_zero_flag_decoder_row.sv
// Directed bench for zero_flag_decoder_row: a 16-bit-counter instance and a 4-bit-counter
// instance see the same stimulus; the narrow one exercises counter saturation.
module tb_zero_flag_decoder_row;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [39:0] in_vec = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        stat_clr = 1'b0;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   zero_flag_decoder_row_if #(.bw(4), .row(8), .cnt_bw(16)) if16 ();
   zero_flag_decoder_row_if #(.bw(4), .row(8), .cnt_bw(4))  if4 ();

   assign if16.in        = in_vec;
   assign if16.in_valid  = in_valid;
   assign if16.out_ready = out_ready;
   assign if16.stat_clr  = stat_clr;
   assign if4.in         = in_vec;
   assign if4.in_valid   = in_valid;
   assign if4.out_ready  = out_ready;
   assign if4.stat_clr   = stat_clr;

   zero_flag_decoder_row #(.bw(4), .row(8), .cnt_bw(16)) dut16 (
      .clk(clk), .reset(reset), .bus(if16.slave));
   zero_flag_decoder_row #(.bw(4), .row(8), .cnt_bw(4)) dut4 (
      .clk(clk), .reset(reset), .bus(if4.slave));

   typedef struct {
      logic [7:0]  flags;
      logic [31:0] data;
      logic [31:0] e_out;
      logic [7:0]  e_gate;
      logic        e_az;
      logic [7:0]  e_err;
   } vec_t;

   vec_t tbl [6];

   function automatic logic [39:0] pack(input logic [7:0] flags, input logic [31:0] data);
      logic [39:0] v;
      for (int i = 0; i < 8; i++) v[5*i +: 5] = {flags[i], data[4*i +: 4]};
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{8'hAC, 32'h050F0012, 32'h050F0012, 8'h53, 1'b0, 8'h00};
      tbl[1] = '{8'hFF, 32'h00000000, 32'h00000000, 8'h00, 1'b1, 8'h00};
      tbl[2] = '{8'h04, 32'h11011311, 32'h11011011, 8'hFB, 1'b0, 8'h24};
      tbl[3] = '{8'h00, 32'h12345678, 32'h12345678, 8'hFF, 1'b0, 8'h00};
      tbl[4] = '{8'hFF, 32'hFFFFFFFF, 32'h00000000, 8'h00, 1'b1, 8'hFF};
      tbl[5] = '{8'h00, 32'h00000000, 32'h00000000, 8'hFF, 1'b0, 8'hFF};

      // Reset state
      #12;
      check("rst_out_valid", if16.out_valid, 0);
      check("rst_in_ready", if16.in_ready, 1);
      check("rst_out", if16.out, 0);
      check("rst_gate_en", if16.gate_en, 0);
      check("rst_flag_err", if16.flag_err, 0);
      check("rst_all_zero", if16.all_zero, 0);
      check("rst_zero_cnt", if16.zero_cnt, 0);
      check("rst_vec_cnt", if16.vec_cnt, 0);
      check("rst_err_sticky", if16.err_sticky, 0);
      reset = 1'b0;
      tick();

      // Table vectors, one at a time with out_ready held high
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_vec   = pack(tbl[k].flags, tbl[k].data);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         check($sformatf("v%0d_out_valid", k), if16.out_valid, 1);
         check($sformatf("v%0d_out", k), if16.out, tbl[k].e_out);
         check($sformatf("v%0d_gate_en", k), if16.gate_en, tbl[k].e_gate);
         check($sformatf("v%0d_all_zero", k), if16.all_zero, tbl[k].e_az);
         check($sformatf("v%0d_flag_err", k), if16.flag_err, tbl[k].e_err);
         tick();
         if (k == 0) begin
            check("v0_zero_cnt", if16.zero_cnt, 4);
            check("v0_vec_cnt", if16.vec_cnt, 1);
            check("v0_err_sticky", if16.err_sticky, 0);
         end
      end
      check("tbl_vec_cnt", if16.vec_cnt, 6);
      check("tbl_zero_cnt", if16.zero_cnt, 21);
      check("tbl_err_sticky", if16.err_sticky, 1);
      check("tbl_vec_cnt4", if4.vec_cnt, 6);
      check("tbl_zero_cnt4_clamp", if4.zero_cnt, 15);

      // stat_clr on the same edge as a handshake of a 3-zero vector
      in_vec   = pack(8'h07, 32'h11111000);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("clr_hs_zero_cnt", if16.zero_cnt, 0);
      check("clr_hs_vec_cnt", if16.vec_cnt, 0);
      check("clr_hs_err_sticky", if16.err_sticky, 0);
      check("clr_hs_out_valid", if16.out_valid, 0);

      // err_sticky holds until stat_clr
      in_vec   = pack(tbl[2].flags, tbl[2].data);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("sticky_set", if16.err_sticky, 1);
      repeat (3) tick();
      check("sticky_hold", if16.err_sticky, 1);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("sticky_clr", if16.err_sticky, 0);
      check("sticky_clr_vec_cnt", if16.vec_cnt, 0);

      // Back-pressure: A in head, B in skid, C held off
      out_ready = 1'b0;
      in_vec = pack(8'h00, 32'h11111111); in_valid = 1'b1; tick();
      in_vec = pack(8'h00, 32'h22222222); tick();
      in_vec = pack(8'h00, 32'h33333333); tick();
      check("bp_out_valid", if16.out_valid, 1);
      check("bp_head_a", if16.out, 32'h11111111);
      check("bp_in_ready", if16.in_ready, 0);
      tick();
      check("bp_head_a_hold", if16.out, 32'h11111111);
      out_ready = 1'b1;
      tick();
      check("bp_head_b", if16.out, 32'h22222222);
      check("bp_in_ready_back", if16.in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("bp_head_c", if16.out, 32'h33333333);
      check("bp_c_valid", if16.out_valid, 1);
      tick();
      check("bp_drained", if16.out_valid, 0);
      check("bp_out_hold", if16.out, 32'h33333333);
      check("bp_vec_cnt", if16.vec_cnt, 3);
      check("bp_zero_cnt", if16.zero_cnt, 0);

      // Saturation: 20 all-zero vectors streamed
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      in_vec   = pack(8'hFF, 32'h00000000);
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         check($sformatf("sat_all_zero_%0d", k), {if4.out_valid, if4.all_zero}, 2'b11);
      end
      in_valid = 1'b0;
      tick();
      check("sat_zero_cnt4", if4.zero_cnt, 15);
      check("sat_vec_cnt4", if4.vec_cnt, 15);
      check("sat_zero_cnt16", if16.zero_cnt, 160);
      check("sat_vec_cnt16", if16.vec_cnt, 20);

      // Asynchronous reset with head and skid full
      out_ready = 1'b0;
      in_vec = pack(8'h00, 32'h44444444); in_valid = 1'b1; tick();
      in_vec = pack(8'h00, 32'h55555555); tick();
      in_valid = 1'b0;
      check("pre_rst_in_ready", if16.in_ready, 0);
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", if16.out_valid, 0);
      check("arst_in_ready", if16.in_ready, 1);
      check("arst_vec_cnt", if16.vec_cnt, 0);
      check("arst_zero_cnt4", if4.zero_cnt, 0);
      check("arst_out", if16.out, 0);
      #1 reset = 1'b0;
      tick();
      in_vec    = pack(8'h00, 32'h89ABCDEF);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("post_rst_latency", if16.out_valid, 1);
      check("post_rst_out", if16.out, 32'h89ABCDEF);
      tick();
      check("post_rst_drained", if16.out_valid, 0);
      check("post_rst_vec_cnt", if16.vec_cnt, 1);
      tick();
      check("post_rst_no_stale", if16.out_valid, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
